// File: rtl/slot_game_ctrl.sv
// Three-reel slot machine sequencer: button press detection, reel rotation,
// bet deduction, payout evaluation, win-banner timing and cash-out.
module slot_game_ctrl #(
    parameter logic [9:0] INIT_MONEY = 10'd100,
    parameter logic [9:0] MAX_MONEY  = 10'd999,
    parameter logic [9:0] BET        = 10'd5,
    parameter logic [9:0] COIN       = 10'd10,
    parameter logic [9:0] PAY2       = 10'd10,
    parameter logic [9:0] PAY3       = 10'd50,
    parameter int         ROT_DIV    = 4,
    parameter int         WIN_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_coin,
    input  logic       btn_spin,
    input  logic       btn_cancel,
    output logic [1:0] state1,
    output logic [1:0] state2,
    output logic [1:0] state3,
    output logic [9:0] money,
    output logic       win,
    output logic [2:0] phase,
    output logic       cashout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN3 = 3'd1,
        SPIN2 = 3'd2,
        SPIN1 = 3'd3,
        EVAL  = 3'd4,
        SHOW  = 3'd5
    } phase_t;

    localparam int DIV_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
    localparam int SHOW_W = (WIN_FRAMES > 1) ? $clog2(WIN_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ROT_DIV - 1);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(WIN_FRAMES - 1);

    phase_t              cur_phase;
    logic [DIV_W-1:0]    div_cnt;
    logic [SHOW_W-1:0]   show_cnt;
    logic                coin_prev, spin_prev, cancel_prev;
    logic                armed;
    logic                coin_press, spin_press, cancel_press;
    logic                step;
    logic                can_bet;
    logic [9:0]          payout;
    logic [10:0]         coin_sum, pay_sum;
    logic [9:0]          coin_money, pay_money;

    assign phase = cur_phase;

    // armed stays low for the first edge after reset so a button held
    // through reset release is absorbed into the previous-level registers
    assign cancel_press = armed & btn_cancel & ~cancel_prev;
    assign spin_press   = armed & btn_spin   & ~spin_prev;
    assign coin_press   = armed & btn_coin   & ~coin_prev;

    assign step    = frame_tick && (div_cnt == DIV_LAST);
    assign can_bet = (money >= BET);

    always_comb begin
        payout = 10'd0;
        if (state1 == state2 && state2 == state3)
            payout = PAY3;
        else if (state1 == state2 || state2 == state3)
            payout = PAY2;
    end

    assign coin_sum   = {1'b0, money} + {1'b0, COIN};
    assign pay_sum    = {1'b0, money} + {1'b0, payout};
    assign coin_money = (coin_sum > {1'b0, MAX_MONEY}) ? MAX_MONEY : coin_sum[9:0];
    assign pay_money  = (pay_sum  > {1'b0, MAX_MONEY}) ? MAX_MONEY : pay_sum[9:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_phase   <= IDLE;
            state1      <= 2'd0;
            state2      <= 2'd0;
            state3      <= 2'd0;
            money       <= INIT_MONEY;
            win         <= 1'b0;
            cashout     <= 1'b0;
            div_cnt     <= '0;
            show_cnt    <= '0;
            coin_prev   <= 1'b0;
            spin_prev   <= 1'b0;
            cancel_prev <= 1'b0;
            armed       <= 1'b0;
        end else begin
            armed       <= 1'b1;
            coin_prev   <= btn_coin;
            spin_prev   <= btn_spin;
            cancel_prev <= btn_cancel;
            cashout     <= 1'b0;

            case (cur_phase)
                IDLE: begin
                    if (cancel_press) begin
                        money   <= 10'd0;
                        cashout <= 1'b1;
                    end else if (spin_press) begin
                        if (can_bet) begin
                            money     <= money - BET;
                            div_cnt   <= '0;
                            cur_phase <= SPIN3;
                        end
                    end else if (coin_press) begin
                        money <= coin_money;
                    end
                end

                SPIN3, SPIN2, SPIN1: begin
                    if (frame_tick)
                        div_cnt <= step ? '0 : div_cnt + 1'b1;
                    if (cancel_press) begin
                        cur_phase <= EVAL;
                    end else begin
                        if (spin_press)
                            cur_phase <= phase_t'(cur_phase + 3'd1);
                        // the reel being stopped this cycle keeps its value
                        if (step) begin
                            if (cur_phase == SPIN3 && !spin_press)
                                state1 <= state1 + 2'd1;
                            if (cur_phase == SPIN3 || (cur_phase == SPIN2 && !spin_press))
                                state2 <= state2 + 2'd1;
                            if (!(cur_phase == SPIN1 && spin_press))
                                state3 <= state3 + 2'd1;
                        end
                    end
                end

                EVAL: begin
                    money     <= pay_money;
                    win       <= (payout != 10'd0);
                    show_cnt  <= '0;
                    cur_phase <= SHOW;
                end

                SHOW: begin
                    if (cancel_press) begin
                        win       <= 1'b0;
                        cur_phase <= IDLE;
                    end else if (spin_press) begin
                        win <= 1'b0;
                        if (can_bet) begin
                            money     <= money - BET;
                            div_cnt   <= '0;
                            cur_phase <= SPIN3;
                        end else begin
                            cur_phase <= IDLE;
                        end
                    end else if (frame_tick) begin
                        if (show_cnt == SHOW_LAST) begin
                            win       <= 1'b0;
                            cur_phase <= IDLE;
                        end else begin
                            show_cnt <= show_cnt + 1'b1;
                        end
                    end
                end

                default: cur_phase <= IDLE;
            endcase
        end
    end

endmodule
